// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU scheduler: opcodes, default
// datapath width and the response-register state type.
package alu_sched_pkg;

    localparam int LEN_DEFAULT = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU shared by both requesters. Compare ops reuse the
// subtractor, so their flags are the flags of A-B.
module alu_core
    import alu_sched_pkg::*;
#(
    parameter int LEN = LEN_DEFAULT
) (
    input  logic [2:0]     op,
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    output logic [LEN-1:0] result,
    output logic           carry,
    output logic           zero,
    output logic           overflow
);

    logic [LEN:0] sum;
    logic [LEN:0] diff;
    logic         add_ovf;
    logic         sub_ovf;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign add_ovf = (a[LEN-1] == b[LEN-1]) && (sum[LEN-1] != a[LEN-1]);
    assign sub_ovf = (a[LEN-1] != b[LEN-1]) && (diff[LEN-1] != a[LEN-1]);

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        zero     = 1'b0;
        unique case (op)
            OP_ADD: begin
                result   = sum[LEN-1:0];
                carry    = sum[LEN];
                overflow = add_ovf;
                zero     = ~|sum[LEN-1:0];
            end
            OP_SUB, OP_SLT, OP_EQ: begin
                // diff[LEN] is the borrow of the zero-extended subtraction
                carry    = diff[LEN];
                overflow = sub_ovf;
                zero     = ~|diff[LEN-1:0];
                if (op == OP_SUB)
                    result = diff[LEN-1:0];
                else if (op == OP_SLT)
                    result = {{(LEN-1){1'b0}}, diff[LEN-1] ^ sub_ovf};
                else
                    result = {{(LEN-1){1'b0}}, ~|diff[LEN-1:0]};
            end
            OP_NOT: begin
                result = ~a;
                zero   = ~|(~a);
            end
            OP_AND: begin
                result = a & b;
                zero   = ~|(a & b);
            end
            OP_OR: begin
                result = a | b;
                zero   = ~|(a | b);
            end
            default: begin
                result = a ^ b;
                zero   = ~|(a ^ b);
            end
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler feeding two requesters into one ALU, with a single
// registered response slot and saturating per-requester grant counters.
//
//   state     | meaning
//   RSP_EMPTY | response register holds nothing, issue slot always free
//   RSP_FULL  | result waiting for consumer, slot free only when rsp_ready
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int LEN  = LEN_DEFAULT,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [LEN-1:0]  req0_a,
    input  logic [LEN-1:0]  req0_b,
    input  logic [2:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [LEN-1:0]  req1_a,
    input  logic [LEN-1:0]  req1_b,
    input  logic [2:0]      req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [LEN-1:0]  rsp_result,
    output logic            rsp_carry,
    output logic            rsp_zero,
    output logic            rsp_overflow,
    output logic [CNTW-1:0] grant_cnt0,
    output logic [CNTW-1:0] grant_cnt1
);

    rsp_state_t     state_q;
    rsp_state_t     state_d;
    logic           last_grant;
    logic           slot_free;
    logic           xfer;
    logic           gid;
    logic [LEN-1:0] alu_a;
    logic [LEN-1:0] alu_b;
    logic [2:0]     alu_op;
    logic [LEN-1:0] alu_res;
    logic           alu_c;
    logic           alu_z;
    logic           alu_o;

    assign slot_free = (state_q == RSP_EMPTY) || rsp_ready;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && slot_free) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant;
                req1_ready = !last_grant;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign xfer   = req0_ready | req1_ready;
    assign gid    = req1_ready;
    assign alu_a  = gid ? req1_a  : req0_a;
    assign alu_b  = gid ? req1_b  : req0_b;
    assign alu_op = gid ? req1_op : req0_op;

    alu_core #(.LEN(LEN)) u_alu (
        .op       (alu_op),
        .a        (alu_a),
        .b        (alu_b),
        .result   (alu_res),
        .carry    (alu_c),
        .zero     (alu_z),
        .overflow (alu_o)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= RSP_EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RSP_EMPTY: if (xfer) state_d = RSP_FULL;
            RSP_FULL:  if (rsp_ready && !xfer) state_d = RSP_EMPTY;
            default:   state_d = RSP_EMPTY;
        endcase
    end

    assign rsp_valid = (state_q == RSP_FULL);

    // Payload only moves on a transfer, so it holds while the slot is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            last_grant   <= 1'b1;
        end else if (xfer) begin
            rsp_id       <= gid;
            rsp_result   <= alu_res;
            rsp_carry    <= alu_c;
            rsp_zero     <= alu_z;
            rsp_overflow <= alu_o;
            last_grant   <= gid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && (grant_cnt0 != '1))
                grant_cnt0 <= grant_cnt0 + CNTW'(1);
            if (req1_ready && (grant_cnt1 != '1))
                grant_cnt1 <= grant_cnt1 + CNTW'(1);
        end
    end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter LEN, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter CNTW, default 16, meaning width of per-requester grant counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-006 req0_ready / req1_ready  output  1 each  operation from requester n accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  LEN each  operands.
REQ-008 req0_op / req1_op  input  3 each  ALU opcode: 000 add, 001 sub, 010 not A, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
REQ-009 rsp_valid  output  1  response register holds a result.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_id  output  1  requester index that owns the response.
REQ-012 rsp_result  output  LEN  registered ALU result.
REQ-013 rsp_carry / rsp_zero / rsp_overflow  output  1 each  registered ALU flags.
REQ-014 grant_cnt0 / grant_cnt1  output  CNTW each  accepted-operation count per requester.

Function
REQ-015 Transfer on a port occurs when valid and ready are both high in the same cycle; valid and payload SHALL be held by requesters until transfer.
REQ-016 Issue slot free SHALL mean: !rsp_valid, or rsp_valid && rsp_ready in the same cycle.
REQ-017 When slot free, exactly one valid requester SHALL be granted; no readies when slot not free or no request valid.
REQ-018 Arbitration: single valid requester wins; both valid, the requester not granted last SHALL win (round-robin); last_grant resets to 1, so requester 0 wins first contention.
REQ-019 last_grant SHALL update only on a transfer.
REQ-020 Granted operands/op SHALL drive one shared combinational ALU; result and flags SHALL be captured into the response register on the transfer edge, latency exactly 1 cycle.
REQ-021 Response register states: EMPTY -> FULL on transfer; FULL -> EMPTY on rsp_ready with no new transfer; FULL -> FULL (new payload) on rsp_ready with simultaneous transfer; FULL holds payload unchanged while rsp_ready low.
REQ-022 Back-to-back throughput SHALL be one operation per cycle while rsp_ready stays high.
REQ-023 Flag semantics: carry = carry-out for add, borrow for sub/compare; zero = adder output all zero; overflow = two's-complement signed overflow of the add/sub; result for 110 = {0..., sign of A-B corrected by overflow}, for 111 = {0..., A==B}.
REQ-024 Result/flags for logic ops SHALL be the logic value with carry=0, overflow=0, zero = (result==0).
REQ-025 grant_cntN SHALL increment by 1 per transfer from requester N and saturate at all-ones.
REQ-026 rsp_id, result and flags SHALL be don't-care-stable (hold last value) while rsp_valid low.

Reset
REQ-027 On rst high at a clock edge: rsp_valid=0, rsp_id=0, rsp_result=0, all flags=0, grant_cnt0=grant_cnt1=0, last_grant=1.
REQ-028 During the reset cycle req0_ready and req1_ready SHALL be 0; a response pending when reset asserts SHALL be discarded.

Structure
REQ-029 Package alu_sched_pkg SHALL hold the 3-bit opcode localparams and the default LEN.
REQ-030 The ALU datapath SHALL be one sub-module, alu_core (LEN-parameterised, combinational), instantiated once.
REQ-031 Arbiter, response register and counters SHALL live in alu_sched itself.

Verification
REQ-032 Reset, then req0 add A=5,B=3 alone, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=8, carry=0, zero=1'b0, overflow=0.
REQ-033 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; grant_cnt0=grant_cnt1 after even cycle count.
REQ-034 req1 sub A=0x7FFFFFFF,B=0xFFFFFFFF -> result 0x80000000, overflow=1; op 110 A=0xFFFFFFFF,B=1 -> result 1.
REQ-035 rsp_ready=0 for 3 cycles with response full -> both readies 0, payload stable; rsp_ready=1 with req0 valid -> same-cycle drain and refill, rsp_valid stays 1.
REQ-036 Assert rst with response full and both requesting -> next cycle rsp_valid=0, counters 0, first subsequent contention granted to requester 0.
REQ-037 Force grant_cnt0 to all-ones minus 1, two more req0 transfers -> counter saturates at all-ones.
